// File: rtl/sipo_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_word_assembler_pkg
//  Brief    : Shared constants and helpers for the serial-to-word assembler.
//  Revision : 1.0  initial release
// ============================================================================
package sipo_word_assembler_pkg;

  // Discarded-partial-word counter geometry
  localparam int                    DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

  // Shift-direction encoding for the MSB_FIRST parameter
  localparam int SHIFT_MSB_FIRST = 1;
  localparam int SHIFT_LSB_FIRST = 0;

  // Ceiling log2; used to size the bit counter as clog2(WIDTH+1)
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_shift_reg
//  Brief    : Serial shift register and bit counter. Counts 0..WIDTH, where
//             WIDTH means a completed word is parked here waiting for the
//             output slot. Flush clears only a partial word.
//  Revision : 1.0  initial release
// ============================================================================
module sipo_shift_reg
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = SHIFT_MSB_FIRST
) (
  input  logic             clock,
  input  logic             clearb,
  input  logic             bit_in,
  input  logic             shift_en,   // bit accepted this cycle
  input  logic             flush,
  input  logic             slot_free,  // output slot can take a word this cycle
  output logic [WIDTH-1:0] sr,
  output logic [WIDTH-1:0] assembled,  // sr with bit_in shifted in
  output logic             full,       // completed word parked in sr
  output logic             last,       // next accepted bit completes a word
  output logic             partial     // 1..WIDTH-1 bits collected
);

  localparam int               CNT_W    = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ZERO_CNT = '0;

  logic [CNT_W-1:0] cnt;

  // Shift direction is fixed at elaboration time
  generate
    if (MSB_FIRST == SHIFT_MSB_FIRST) begin : g_msb_first
      assign assembled = {sr[WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
      assign assembled = {bit_in, sr[WIDTH-1:1]};
    end
  endgenerate

  assign full    = (cnt == FULL_CNT);
  assign last    = (cnt == LAST_CNT);
  assign partial = (cnt != ZERO_CNT) && !full;

  // Shift/count update; accept excludes both full and flush upstream, so the
  // branches below are mutually exclusive in practice.
  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr <= assembled;
      if (last) begin
        // Word done: hand off immediately or park it until the slot frees
        cnt <= slot_free ? ZERO_CNT : FULL_CNT;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (full && slot_free) begin
      cnt <= ZERO_CNT;
    end else if (flush && partial) begin
      sr  <= '0;
      cnt <= ZERO_CNT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sipo_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_word_assembler
//  Brief    : Assembles a qualified serial bit stream into WIDTH-bit words,
//             presented on a one-entry valid/ready slot with backpressure to
//             the bit source. Flush discards a partial word and bumps a
//             saturating drop counter.
//  Revision : 1.0  initial release
// ============================================================================
module sipo_word_assembler
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = SHIFT_MSB_FIRST
) (
  input  logic                  clock,
  input  logic                  clearb,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [DROP_CNT_W-1:0] drop_count
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] assembled;
  logic             full;
  logic             last;
  logic             partial;
  logic             accept;
  logic             slot_free;
  logic             load_new;
  logic             load_pend;
  logic             drop;

  // Ready depends only on state and flush, never on bit_valid
  assign bit_ready = !flush && !full;
  assign accept    = bit_valid && bit_ready;
  assign slot_free = !word_valid || word_ready;
  assign load_new  = accept && last && slot_free;
  assign load_pend = full && slot_free;
  assign drop      = flush && partial;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clock     (clock),
    .clearb    (clearb),
    .bit_in    (bit_in),
    .shift_en  (accept),
    .flush     (flush),
    .slot_free (slot_free),
    .sr        (sr),
    .assembled (assembled),
    .full      (full),
    .last      (last),
    .partial   (partial)
  );

  // Output slot: load a fresh or parked word, otherwise drain on ready
  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (load_new) begin
      word_out   <= assembled;
      word_valid <= 1'b1;
    end else if (load_pend) begin
      word_out   <= sr;
      word_valid <= 1'b1;
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end

  // Saturating count of partial words thrown away by flush
  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      drop_count <= '0;
    end else if (drop && (drop_count != DROP_CNT_MAX)) begin
      drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sipo_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_word_assembler
//  Brief    : Self-checking bench; expected words queued as bits are sent and
//             compared when the DUT hands them off.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sipo_word_assembler;

  logic       clock = 1'b0;
  logic       clearb;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       flush;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic [7:0] drop_count;

  logic       bit_ready_l;
  logic [7:0] word_out_l;
  logic       word_valid_l;
  logic [7:0] drop_count_l;

  int         passed = 0;
  int         total  = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  sipo_word_assembler #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clock(clock), .clearb(clearb), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .flush(flush), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .drop_count(drop_count)
  );

  sipo_word_assembler #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clock(clock), .clearb(clearb), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_l), .flush(flush), .word_out(word_out_l),
    .word_valid(word_valid_l), .word_ready(word_ready), .drop_count(drop_count_l)
  );

  // Scoreboard: a handshake completes at the next edge, so judge it mid-cycle
  always @(negedge clock) begin
    if (clearb && word_valid && word_ready) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: unexpected word %02h, none expected", word_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (word_out !== e) $display("FAIL scoreboard: word_out=%02h expected %02h", word_out, e);
        else passed = passed + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Send the top n bits of w, MSB first, honouring bit_ready
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      int waited;
      waited    = 0;
      bit_in    = w[i];
      bit_valid = 1'b1;
      forever begin
        #1;
        if (bit_ready) begin
          tick();
          break;
        end
        tick();
        waited++;
        if (waited > 50) begin
          total = total + 1;
          $display("FAIL send_timeout: bit_ready=%0b after %0d cycles, required 1", bit_ready, waited);
          break;
        end
      end
    end
    bit_valid = 1'b0;
  endtask

  task automatic drain_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #3;
    total += 4;
    if (word_valid !== 1'b0) $display("FAIL reset_valid: %0b required 0", word_valid); else passed++;
    if (word_out !== 8'h00) $display("FAIL reset_word: %02h required 00", word_out); else passed++;
    if (drop_count !== 8'h00) $display("FAIL reset_drop: %0d required 0", drop_count); else passed++;
    if (bit_ready !== 1'b1) $display("FAIL reset_ready: %0b required 1", bit_ready); else passed++;
    tick();
    clearb = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] w;
    bit ok;
    w = 8'hB2;
    word_ready = 1'b1;
    exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      bit_in    = w[i];
      bit_valid = 1'b1;
      #1;
      total++;
      if (bit_ready !== 1'b1) $display("FAIL basic_ready: bit %0d ready=%0b required 1", i, bit_ready); else passed++;
      tick();
    end
    bit_valid = 1'b0;
    total++;
    if (word_valid !== 1'b1) $display("FAIL basic_valid_rise: %0b required 1", word_valid); else passed++;
    tick();
    total += 2;
    if (word_valid !== 1'b0) $display("FAIL basic_valid_pulse: %0b required 0", word_valid); else passed++;
    drain_wait(ok);
    if (!ok) $display("FAIL basic_drain: %0d words left, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_bit_order();
    bit ok;
    word_ready = 1'b1;
    exp_q.push_back(8'hB2);
    send_bits(8'hB2, 8);
    total += 4;
    if (word_valid_l !== 1'b1) $display("FAIL order_valid: %0b required 1", word_valid_l); else passed++;
    if (word_out_l !== 8'h4D) $display("FAIL order_word: %02h required 4d", word_out_l); else passed++;
    if (bit_ready_l !== 1'b1) $display("FAIL order_ready: %0b required 1", bit_ready_l); else passed++;
    if (drop_count_l !== 8'h00) $display("FAIL order_drop: %0d required 0", drop_count_l); else passed++;
    drain_wait(ok);
  endtask

  task automatic test_backpressure();
    bit ok;
    word_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8);
    total += 2;
    if (word_valid !== 1'b1) $display("FAIL bp_valid: %0b required 1", word_valid); else passed++;
    if (word_out !== 8'hA5) $display("FAIL bp_hold: %02h required a5", word_out); else passed++;
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8);
    total += 2;
    if (bit_ready !== 1'b0) $display("FAIL bp_ready_low: %0b required 0", bit_ready); else passed++;
    if (word_out !== 8'hA5) $display("FAIL bp_stable: %02h required a5", word_out); else passed++;
    repeat (3) tick();
    total += 2;
    if (word_out !== 8'hA5 || word_valid !== 1'b1) $display("FAIL bp_stall: word %02h valid %0b required a5/1", word_out, word_valid); else passed++;
    if (bit_ready !== 1'b0) $display("FAIL bp_stall_ready: %0b required 0", bit_ready); else passed++;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    total += 3;
    if (word_out !== 8'h3C) $display("FAIL bp_transfer: %02h required 3c", word_out); else passed++;
    if (word_valid !== 1'b1) $display("FAIL bp_transfer_valid: %0b required 1", word_valid); else passed++;
    if (bit_ready !== 1'b1) $display("FAIL bp_ready_back: %0b required 1", bit_ready); else passed++;
    word_ready = 1'b1;
    tick();
    total += 2;
    if (word_valid !== 1'b0) $display("FAIL bp_consumed: %0b required 0", word_valid); else passed++;
    if (word_out !== 8'h3C) $display("FAIL bp_retain: %02h required 3c", word_out); else passed++;
    drain_wait(ok);
    total++;
    if (!ok) $display("FAIL bp_drain: %0d words left, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_flush();
    bit ok;
    word_ready = 1'b1;
    send_bits(8'hE0, 3);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    flush     = 1'b1;
    #1;
    total++;
    if (bit_ready !== 1'b0) $display("FAIL flush_ready: %0b required 0", bit_ready); else passed++;
    tick();
    flush     = 1'b0;
    bit_valid = 1'b0;
    total++;
    if (drop_count !== 8'd1) $display("FAIL flush_drop: %0d required 1", drop_count); else passed++;
    exp_q.push_back(8'hF0);
    send_bits(8'hF0, 8);
    drain_wait(ok);
    total++;
    if (!ok) $display("FAIL flush_drain: %0d words left, required 0", exp_q.size()); else passed++;
    // Flush while a completed word is parked must not discard it
    word_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_bits(8'h11, 8);
    exp_q.push_back(8'h77);
    send_bits(8'h77, 8);
    flush = 1'b1;
    tick();
    total += 2;
    if (drop_count !== 8'd1) $display("FAIL flush_full_drop: %0d required 1", drop_count); else passed++;
    if (word_out !== 8'h11) $display("FAIL flush_full_word: %02h required 11", word_out); else passed++;
    word_ready = 1'b1;
    tick();
    total += 3;
    if (word_out !== 8'h77) $display("FAIL flush_transfer: %02h required 77", word_out); else passed++;
    if (word_valid !== 1'b1) $display("FAIL flush_transfer_valid: %0b required 1", word_valid); else passed++;
    if (drop_count !== 8'd1) $display("FAIL flush_transfer_drop: %0d required 1", drop_count); else passed++;
    flush = 1'b0;
    drain_wait(ok);
    total++;
    if (!ok) $display("FAIL flush_full_drain: %0d words left, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_async_clear();
    bit ok;
    word_ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8);
    send_bits(8'hFF, 5);
    #2;
    clearb = 1'b0;
    #1;
    total += 4;
    if (word_valid !== 1'b0) $display("FAIL clr_valid: %0b required 0", word_valid); else passed++;
    if (word_out !== 8'h00) $display("FAIL clr_word: %02h required 00", word_out); else passed++;
    if (drop_count !== 8'h00) $display("FAIL clr_drop: %0d required 0", drop_count); else passed++;
    if (bit_ready !== 1'b1) $display("FAIL clr_ready: %0b required 1", bit_ready); else passed++;
    exp_q.delete();
    #1;
    clearb = 1'b1;
    tick();
    word_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_bits(8'hC3, 8);
    drain_wait(ok);
    total++;
    if (!ok) $display("FAIL clr_after: %0d words left, required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_saturation();
    word_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send_bits(8'h80, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      if (i == 254) begin
        total++;
        if (drop_count !== 8'd255) $display("FAIL sat_reach: %0d required 255", drop_count); else passed++;
      end
    end
    total++;
    if (drop_count !== 8'd255) $display("FAIL sat_hold: %0d required 255", drop_count); else passed++;
  endtask

  initial begin
    clearb     = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b0;
    test_reset();
    test_basic();
    test_bit_order();
    test_backpressure();
    test_flush();
    test_async_clear();
    test_saturation();
    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
